// File: rtl/instr_sequencer_pkg.sv
// Shared encodings for the SIMPLE RISC Machine control path: FSM states,
// register/write-back selects, opcodes and the instruction classifier.
package instr_sequencer_pkg;

  typedef enum logic [4:0] {
    S_RST    = 5'd0,
    S_IF1    = 5'd1,
    S_IF2    = 5'd2,
    S_UPD_PC = 5'd3,
    S_DECODE = 5'd4,
    S_WR_IMM = 5'd5,
    S_GET_A  = 5'd6,
    S_GET_B  = 5'd7,
    S_ALU_Z  = 5'd8,
    S_ALU    = 5'd9,
    S_WR_REG = 5'd10,
    S_CMP    = 5'd11,
    S_ADDR   = 5'd12,
    S_LATCH  = 5'd13,
    S_MEM_RD = 5'd14,
    S_LD_WB  = 5'd15,
    S_GET_RD = 5'd16,
    S_PASS   = 5'd17,
    S_MEM_WR = 5'd18,
    S_HALT   = 5'd19
  } state_t;

  localparam logic [1:0] NSEL_RN = 2'b00;
  localparam logic [1:0] NSEL_RD = 2'b01;
  localparam logic [1:0] NSEL_RM = 2'b10;

  localparam logic [1:0] VSEL_C     = 2'b00;
  localparam logic [1:0] VSEL_PC    = 2'b01;
  localparam logic [1:0] VSEL_IMM   = 2'b10;
  localparam logic [1:0] VSEL_MDATA = 2'b11;

  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_ADD     = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_AND     = 2'b10;
  localparam logic [1:0] OP_MVN     = 2'b11;

  typedef enum logic [3:0] {
    I_MOV_IMM = 4'd0,
    I_MOV_REG = 4'd1,
    I_ADD     = 4'd2,
    I_AND     = 4'd3,
    I_CMP     = 4'd4,
    I_MVN     = 4'd5,
    I_LDR     = 4'd6,
    I_STR     = 4'd7,
    I_HALT    = 4'd8,
    I_UNDEF   = 4'd9
  } instr_t;

  // Anything outside the defined {opcode,op} pairs classifies as I_UNDEF (NOP).
  function automatic instr_t decode_instr(input logic [2:0] opcode, input logic [1:0] op);
    instr_t k;
    k = I_UNDEF;
    case (opcode)
      OPC_MOV: begin
        case (op)
          OP_MOV_IMM: k = I_MOV_IMM;
          OP_MOV_REG: k = I_MOV_REG;
          default:    k = I_UNDEF;
        endcase
      end
      OPC_ALU: begin
        case (op)
          OP_ADD:  k = I_ADD;
          OP_CMP:  k = I_CMP;
          OP_AND:  k = I_AND;
          OP_MVN:  k = I_MVN;
          default: k = I_UNDEF;
        endcase
      end
      OPC_LDR: begin
        if (op == 2'b00) k = I_LDR;
        else             k = I_UNDEF;
      end
      OPC_STR: begin
        if (op == 2'b00) k = I_STR;
        else             k = I_UNDEF;
      end
      OPC_HALT: k = I_HALT;
      default:  k = I_UNDEF;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/instr_sequencer_wait_cnt.sv
// Memory-wait down-counter: loads a start value, decrements to zero and
// flags done while it holds zero.
module seq_wait_cnt #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [WIDTH-1:0] cnt_r;

  // Count register: load wins over decrement; saturates at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != '0)) begin
      cnt_r <= cnt_r - WIDTH'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == '0);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle Moore control FSM for the SIMPLE RISC Machine datapath with a
// configurable memory read latency (MEM_WAIT, legal 1..4).
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       loadir,
  output logic       loadpc,
  output logic       reset_pc,
  output logic       load_addr,
  output logic       msel,
  output logic       mwrite,
  output logic [1:0] nsel,
  output logic [1:0] vsel,
  output logic       write,
  output logic       asel,
  output logic       bsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       halted,
  output logic [4:0] state_dbg
);

  localparam logic [1:0] WAIT_INIT = 2'(MEM_WAIT - 1);

  state_t state_r;
  instr_t instr_s;
  logic   wait_load_s;
  logic   wait_done_s;

  assign instr_s = decode_instr(opcode, op);

  // The counter is parked at MEM_WAIT-1 outside the two wait states, so it is
  // already loaded on entry to IF1 or MEM_RD (they are never adjacent).
  assign wait_load_s = !((state_r == S_IF1) || (state_r == S_MEM_RD));

  seq_wait_cnt #(.WIDTH(2)) u_wait_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (wait_load_s),
    .load_val (WAIT_INIT),
    .dec      (!wait_load_s),
    .done     (wait_done_s)
  );

  // State register and next-state selection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_RST;
    end else begin
      case (state_r)
        S_RST:    state_r <= S_IF1;
        S_IF1:    state_r <= wait_done_s ? S_IF2 : S_IF1;
        S_IF2:    state_r <= S_UPD_PC;
        S_UPD_PC: state_r <= S_DECODE;
        S_DECODE: begin
          case (instr_s)
            I_MOV_IMM:                         state_r <= S_WR_IMM;
            I_MOV_REG, I_MVN:                  state_r <= S_GET_B;
            I_ADD, I_AND, I_CMP, I_LDR, I_STR: state_r <= S_GET_A;
            I_HALT:                            state_r <= S_HALT;
            default:                           state_r <= S_IF1;
          endcase
        end
        S_GET_A:  state_r <= ((instr_s == I_LDR) || (instr_s == I_STR)) ? S_ADDR : S_GET_B;
        S_GET_B: begin
          case (instr_s)
            I_MOV_REG, I_MVN: state_r <= S_ALU_Z;
            I_CMP:            state_r <= S_CMP;
            default:          state_r <= S_ALU;
          endcase
        end
        S_ALU_Z, S_ALU:           state_r <= S_WR_REG;
        S_WR_IMM, S_WR_REG, S_CMP: state_r <= S_IF1;
        S_ADDR:   state_r <= S_LATCH;
        S_LATCH:  state_r <= (instr_s == I_LDR) ? S_MEM_RD : S_GET_RD;
        S_MEM_RD: state_r <= wait_done_s ? S_LD_WB : S_MEM_RD;
        S_LD_WB:  state_r <= S_IF1;
        S_GET_RD: state_r <= S_PASS;
        S_PASS:   state_r <= S_MEM_WR;
        S_MEM_WR: state_r <= S_IF1;
        S_HALT:   state_r <= S_HALT;
        default:  state_r <= S_RST;
      endcase
    end
  end

  // Moore output decode from the state register only.
  always_comb begin
    loadir    = 1'b0;
    loadpc    = 1'b0;
    reset_pc  = 1'b0;
    load_addr = 1'b0;
    msel      = 1'b0;
    mwrite    = 1'b0;
    nsel      = NSEL_RN;
    vsel      = VSEL_C;
    write     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    halted    = 1'b0;
    case (state_r)
      S_RST:    begin reset_pc = 1'b1; loadpc = 1'b1; end
      S_IF2:    loadir = 1'b1;
      S_UPD_PC: loadpc = 1'b1;
      S_WR_IMM: begin nsel = NSEL_RN; vsel = VSEL_IMM; write = 1'b1; end
      S_GET_A:  begin nsel = NSEL_RN; loada = 1'b1; end
      S_GET_B:  begin nsel = NSEL_RM; loadb = 1'b1; end
      S_ALU_Z:  begin asel = 1'b1; loadc = 1'b1; end
      S_ALU:    loadc = 1'b1;
      S_WR_REG: begin nsel = NSEL_RD; vsel = VSEL_C; write = 1'b1; end
      S_CMP:    loads = 1'b1;
      S_ADDR:   begin bsel = 1'b1; loadc = 1'b1; end
      S_LATCH:  load_addr = 1'b1;
      S_MEM_RD: msel = 1'b1;
      S_LD_WB:  begin msel = 1'b1; nsel = NSEL_RD; vsel = VSEL_MDATA; write = 1'b1; end
      S_GET_RD: begin nsel = NSEL_RD; loadb = 1'b1; end
      S_PASS:   begin asel = 1'b1; loadc = 1'b1; end
      S_MEM_WR: begin msel = 1'b1; mwrite = 1'b1; end
      S_HALT:   halted = 1'b1;
      default:  halted = 1'b0;
    endcase
  end

  assign state_dbg = state_r;

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: table of instruction vectors with a
// scoreboard of expected per-cycle states, plus reset/HALT/wait corner cases.
module tb_instr_sequencer;
  import instr_sequencer_pkg::*;

  typedef struct packed {
    logic       loadir, loadpc, reset_pc, load_addr, msel, mwrite;
    logic [1:0] nsel, vsel;
    logic       write, asel, bsel, loada, loadb, loadc, loads, halted;
  } out_t;

  typedef struct packed {
    logic [4:0] st;
    logic       sel3;
  } sb_t;

  typedef struct packed {
    logic [2:0]      opc;
    logic [1:0]      op;
    logic [2:0]      nt;
    logic [5:0][4:0] tail;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] opcode = 3'b000;
  logic [1:0] op = 2'b00;

  logic       a_loadir, a_loadpc, a_reset_pc, a_load_addr, a_msel, a_mwrite, a_write;
  logic       a_asel, a_bsel, a_loada, a_loadb, a_loadc, a_loads, a_halted;
  logic [1:0] a_nsel, a_vsel;
  logic [4:0] a_state;
  logic       b_loadir, b_loadpc, b_reset_pc, b_load_addr, b_msel, b_mwrite, b_write;
  logic       b_asel, b_bsel, b_loada, b_loadb, b_loadc, b_loads, b_halted;
  logic [1:0] b_nsel, b_vsel;
  logic [4:0] b_state;
  out_t       o1_s, o3_s;

  int  vec_cnt = 0;
  int  miss_cnt = 0;
  sb_t sb_q[$];
  vec_t vecs [10];

  always #5 clk = ~clk;

  instr_sequencer #(.MEM_WAIT(1)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op),
    .loadir(a_loadir), .loadpc(a_loadpc), .reset_pc(a_reset_pc), .load_addr(a_load_addr),
    .msel(a_msel), .mwrite(a_mwrite), .nsel(a_nsel), .vsel(a_vsel), .write(a_write),
    .asel(a_asel), .bsel(a_bsel), .loada(a_loada), .loadb(a_loadb), .loadc(a_loadc),
    .loads(a_loads), .halted(a_halted), .state_dbg(a_state)
  );

  instr_sequencer #(.MEM_WAIT(3)) dut3 (
    .clk(clk), .reset(reset), .opcode(opcode), .op(op),
    .loadir(b_loadir), .loadpc(b_loadpc), .reset_pc(b_reset_pc), .load_addr(b_load_addr),
    .msel(b_msel), .mwrite(b_mwrite), .nsel(b_nsel), .vsel(b_vsel), .write(b_write),
    .asel(b_asel), .bsel(b_bsel), .loada(b_loada), .loadb(b_loadb), .loadc(b_loadc),
    .loads(b_loads), .halted(b_halted), .state_dbg(b_state)
  );

  assign o1_s = {a_loadir, a_loadpc, a_reset_pc, a_load_addr, a_msel, a_mwrite, a_nsel, a_vsel,
                 a_write, a_asel, a_bsel, a_loada, a_loadb, a_loadc, a_loads, a_halted};
  assign o3_s = {b_loadir, b_loadpc, b_reset_pc, b_load_addr, b_msel, b_mwrite, b_nsel, b_vsel,
                 b_write, b_asel, b_bsel, b_loada, b_loadb, b_loadc, b_loads, b_halted};

  // Expected outputs for each state, written from the state/output table.
  function automatic out_t exp_out(input logic [4:0] st);
    out_t e;
    e = '0;
    case (state_t'(st))
      S_RST:    begin e.reset_pc = 1'b1; e.loadpc = 1'b1; end
      S_IF2:    e.loadir = 1'b1;
      S_UPD_PC: e.loadpc = 1'b1;
      S_WR_IMM: begin e.nsel = 2'b00; e.vsel = 2'b10; e.write = 1'b1; end
      S_GET_A:  begin e.nsel = 2'b00; e.loada = 1'b1; end
      S_GET_B:  begin e.nsel = 2'b10; e.loadb = 1'b1; end
      S_ALU_Z:  begin e.asel = 1'b1; e.loadc = 1'b1; end
      S_ALU:    e.loadc = 1'b1;
      S_WR_REG: begin e.nsel = 2'b01; e.vsel = 2'b00; e.write = 1'b1; end
      S_CMP:    e.loads = 1'b1;
      S_ADDR:   begin e.bsel = 1'b1; e.loadc = 1'b1; end
      S_LATCH:  e.load_addr = 1'b1;
      S_MEM_RD: e.msel = 1'b1;
      S_LD_WB:  begin e.msel = 1'b1; e.nsel = 2'b01; e.vsel = 2'b11; e.write = 1'b1; end
      S_GET_RD: begin e.nsel = 2'b01; e.loadb = 1'b1; end
      S_PASS:   begin e.asel = 1'b1; e.loadc = 1'b1; end
      S_MEM_WR: begin e.msel = 1'b1; e.mwrite = 1'b1; end
      S_HALT:   e.halted = 1'b1;
      default:  e = '0;
    endcase
    return e;
  endfunction

  function automatic logic [5:0][4:0] tl(input logic [4:0] s0, s1, s2, s3, s4, s5);
    return {s5, s4, s3, s2, s1, s0};
  endfunction

  task automatic push(input logic [4:0] st, input logic sel3);
    sb_q.push_back('{st: st, sel3: sel3});
  endtask

  task automatic check_next(input string tag);
    sb_t        e;
    logic [4:0] act_st;
    out_t       act, exp;
    vec_cnt++;
    if (sb_q.size() == 0) begin
      miss_cnt++;
      $display("FAIL %s: scoreboard empty, nothing expected", tag);
    end else begin
      e      = sb_q.pop_front();
      act_st = e.sel3 ? b_state : a_state;
      act    = e.sel3 ? o3_s : o1_s;
      exp    = exp_out(e.st);
      if (act_st !== e.st || act !== exp || (act.write && act.mwrite)) begin
        miss_cnt++;
        $display("FAIL %s: got state=%0d outs=%h, expected state=%0d outs=%h",
                 tag, act_st, act, e.st, exp);
      end
    end
  endtask

  task automatic reset_pulse(input logic sel3);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    push(S_RST, sel3);
    @(negedge clk);
    check_next("reset_release");
  endtask

  initial begin
    vecs[0] = '{opc: 3'b110, op: 2'b10, nt: 3'd1, tail: tl(S_WR_IMM, S_RST, S_RST, S_RST, S_RST, S_RST)};
    vecs[1] = '{opc: 3'b101, op: 2'b00, nt: 3'd4, tail: tl(S_GET_A, S_GET_B, S_ALU, S_WR_REG, S_RST, S_RST)};
    vecs[2] = '{opc: 3'b101, op: 2'b01, nt: 3'd3, tail: tl(S_GET_A, S_GET_B, S_CMP, S_RST, S_RST, S_RST)};
    vecs[3] = '{opc: 3'b101, op: 2'b10, nt: 3'd4, tail: tl(S_GET_A, S_GET_B, S_ALU, S_WR_REG, S_RST, S_RST)};
    vecs[4] = '{opc: 3'b101, op: 2'b11, nt: 3'd3, tail: tl(S_GET_B, S_ALU_Z, S_WR_REG, S_RST, S_RST, S_RST)};
    vecs[5] = '{opc: 3'b110, op: 2'b00, nt: 3'd3, tail: tl(S_GET_B, S_ALU_Z, S_WR_REG, S_RST, S_RST, S_RST)};
    vecs[6] = '{opc: 3'b011, op: 2'b00, nt: 3'd5, tail: tl(S_GET_A, S_ADDR, S_LATCH, S_MEM_RD, S_LD_WB, S_RST)};
    vecs[7] = '{opc: 3'b100, op: 2'b00, nt: 3'd6, tail: tl(S_GET_A, S_ADDR, S_LATCH, S_GET_RD, S_PASS, S_MEM_WR)};
    vecs[8] = '{opc: 3'b110, op: 2'b01, nt: 3'd0, tail: tl(S_RST, S_RST, S_RST, S_RST, S_RST, S_RST)};
    vecs[9] = '{opc: 3'b011, op: 2'b01, nt: 3'd0, tail: tl(S_RST, S_RST, S_RST, S_RST, S_RST, S_RST)};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    push(S_RST, 1'b0);
    @(negedge clk);
    check_next("reset_state");

    // Table: each instruction from IF1 until the cycle before the next IF1.
    for (int v = 0; v < 10; v++) begin
      opcode = vecs[v].opc;
      op     = vecs[v].op;
      push(S_IF1, 1'b0); push(S_IF2, 1'b0); push(S_UPD_PC, 1'b0); push(S_DECODE, 1'b0);
      for (int t = 0; t < int'(vecs[v].nt); t++) push(vecs[v].tail[t], 1'b0);
      repeat (4 + int'(vecs[v].nt)) begin
        @(negedge clk);
        check_next($sformatf("vec%0d", v));
      end
    end
    push(S_IF1, 1'b0);
    @(negedge clk);
    check_next("table_end_if1");

    // MEM_WAIT=3 LDR: IF1 and MEM_RD each last 3 cycles, 13 in total.
    reset_pulse(1'b1);
    opcode = 3'b011; op = 2'b00;
    repeat (3) push(S_IF1, 1'b1);
    push(S_IF2, 1'b1); push(S_UPD_PC, 1'b1); push(S_DECODE, 1'b1);
    push(S_GET_A, 1'b1); push(S_ADDR, 1'b1); push(S_LATCH, 1'b1);
    repeat (3) push(S_MEM_RD, 1'b1);
    push(S_LD_WB, 1'b1); push(S_IF1, 1'b1);
    repeat (14) begin
      @(negedge clk);
      check_next("ldr_wait3");
    end

    // HALT holds while opcode toggles; async reset drops to RST at once.
    reset_pulse(1'b0);
    opcode = 3'b111; op = 2'b00;
    push(S_IF1, 1'b0); push(S_IF2, 1'b0); push(S_UPD_PC, 1'b0); push(S_DECODE, 1'b0); push(S_HALT, 1'b0);
    repeat (5) begin
      @(negedge clk);
      check_next("halt_entry");
    end
    repeat (22) begin
      opcode = 3'($urandom_range(0, 7));
      op     = 2'($urandom_range(0, 3));
      push(S_HALT, 1'b0);
      @(negedge clk);
      check_next("halt_hold");
    end
    @(posedge clk);
    #1 reset = 1'b1;
    push(S_RST, 1'b0);
    #1 check_next("halt_async_reset");
    push(S_RST, 1'b0);
    @(negedge clk);
    check_next("halt_reset_held");
    @(posedge clk);
    #1 reset = 1'b0;
    opcode = 3'b110; op = 2'b01;
    push(S_RST, 1'b0); push(S_IF1, 1'b0); push(S_IF2, 1'b0); push(S_UPD_PC, 1'b0);
    push(S_DECODE, 1'b0); push(S_IF1, 1'b0);
    repeat (6) begin
      @(negedge clk);
      check_next("undef_after_halt");
    end

    // Reset pulsed in ADD's ALU state: no write-back, restart via RST.
    reset_pulse(1'b0);
    opcode = 3'b101; op = 2'b00;
    push(S_IF1, 1'b0); push(S_IF2, 1'b0); push(S_UPD_PC, 1'b0); push(S_DECODE, 1'b0);
    push(S_GET_A, 1'b0); push(S_GET_B, 1'b0); push(S_ALU, 1'b0);
    repeat (7) begin
      @(negedge clk);
      check_next("add_to_alu");
    end
    #2 reset = 1'b1;
    push(S_RST, 1'b0);
    #1 check_next("alu_async_reset");
    push(S_RST, 1'b0);
    @(negedge clk);
    check_next("alu_reset_held");
    @(posedge clk);
    #1 reset = 1'b0;
    push(S_RST, 1'b0); push(S_IF1, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check_next("alu_reset_release");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
